axis_rr_port_arbiter: RTL and testbench
=======================================

Name: axis_rr_port_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one parse/reassembly pipeline (header parser + packet-processing stage) among NUM_PORTS AXI-Stream ingress ports.
- Grants one port at a time and holds the grant until that packet's tlast beat is transferred, so packets never interleave.
- Output is a single registered stage feeding the processing stage's s_axis interface.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, tdata width; tkeep is C_S_AXIS_DATA_WIDTH/8.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width.
- NUM_PORTS, 4, number of ingress ports (2..8).
- SRC_TAG_POS, 24, LSB of 8-bit source-port tag in tuser (used only with the optional feature).

Ports:
- clk  in  1  axis clock; all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH  flattened; port i at [i*W +: W].
- s_axis_tkeep  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH/8  flattened per port.
- s_axis_tuser  in  NUM_PORTS*C_S_AXIS_TUSER_WIDTH  flattened per port.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port last.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  registered.
- m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  registered.
- m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  registered.
- m_axis_tvalid  out  1  registered.
- m_axis_tlast  out  1  registered.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset (async, aresetn low):
  - m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser and m_axis_tlast all 0.
  - State IDLE; grant 0; last_grant NUM_PORTS-1, so port 0 has first priority.
  - s_axis_tready all 0.
- Output register:
  - load_ok = !m_axis_tvalid || m_axis_tready.
  - A beat transfers on port g when state == BUSY, grant == g, s_axis_tvalid[g] and load_ok.
  - On a transfer, the output register captures port g's tdata/tkeep/tuser/tlast and sets m_axis_tvalid = 1.
  - Else if m_axis_tready, m_axis_tvalid clears to 0.
  - Output data is held stable while m_axis_tvalid && !m_axis_tready.
- s_axis_tready[i] = (state == BUSY) && (grant == i) && load_ok. This is combinational from registered state and m_axis_tready; it never depends on s_axis_tvalid.
- State machine:
  - IDLE:
    - If any s_axis_tvalid is set, select the first set bit searching from (last_grant+1) mod NUM_PORTS upward with wrap.
    - Register it into grant and last_grant, then go to BUSY.
    - With no request, stay in IDLE.
  - BUSY:
    - On a transfer with tlast, go to IDLE.
    - Otherwise stay, regardless of the tvalid state of other ports.
- Latency and bubbles:
  - A request seen in IDLE gets tready one cycle later; first output beat is 2 cycles after the request.
  - One idle cycle between back-to-back packets (the arbitration cycle).
- Boundary conditions:
  - Granted port drops tvalid mid-packet: grant is held, no timeout.
  - Single-beat packet (tvalid and tlast together): BUSY lasts exactly one transfer cycle.
  - Simultaneous requests from all ports: grants go strictly in order last_grant+1, +2, …
  - Downstream stall: m_axis_tready low with m_axis_tvalid high blocks every s_axis_tready; no beat is lost or duplicated.
  - Reset mid-packet: output beat discarded, state IDLE; upstream must restart on a packet boundary.

Optional Feature:
- Macro: ARB_SRC_TAG_EN.
- Defined: on load, m_axis_tuser[SRC_TAG_POS +: 8] is replaced with the zero-extended grant index. All other tuser bits pass through unchanged.
- Undefined: tuser passes through unmodified. No tag logic is synthesized.

Test Plan:
- Reset, then port 2 sends a 3-beat packet with tdata 0xA0, 0xA1, 0xA2 and m_axis_tready = 1 -> s_axis_tready[2] rises 1 cycle after tvalid; output beats 0xA0..0xA2 appear on consecutive cycles; m_axis_tlast on 0xA2; state returns to IDLE.
- All 4 ports hold 2-beat packets continuously -> grant sequence 0, 1, 2, 3, 0; exactly one idle output cycle between packets; no interleaving.
- Port 1 mid-packet with port 0 requesting; m_axis_tready held low 5 cycles after beat 1 -> output frozen on beat 1; all s_axis_tready = 0; beat 2 emitted after tready returns; port 0 is granted only after port 1's tlast.
- Granted port 3 drops tvalid for 4 cycles mid-packet while port 0 requests -> grant stays on 3; the packet completes; port 0 is served next.
- aresetn pulsed low mid-packet on port 1 -> m_axis_tvalid goes 0 immediately (async); after release, port 0 wins when both ports request.
- With ARB_SRC_TAG_EN defined, port 2 sends tuser = 0 -> m_axis_tuser[31:24] = 8'h02 on every beat, other bits 0. Without the macro -> tuser = 0.

Source files
------------

// File: rtl/axis_rr_port_arbiter.sv
// Packet-granular round-robin arbiter: NUM_PORTS AXI-Stream ingress ports share one registered output stage.
// Optional build macro ARB_SRC_TAG_EN overwrites tuser[SRC_TAG_POS +: 8] with the granted port index.
//
// state | meaning
// IDLE  | no grant held; arbitrating among requesting ports
// BUSY  | grant held on one port until its tlast beat transfers

module axis_rr_port_arbiter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS            = 4,
    parameter int SRC_TAG_POS          = 24
) (
    input  logic                                            clk,
    input  logic                                            aresetn,
    input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [NUM_PORTS*(C_S_AXIS_DATA_WIDTH/8)-1:0]    s_axis_tkeep,
    input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]       s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                            s_axis_tlast,
    output logic [NUM_PORTS-1:0]                            s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]                m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]                 m_axis_tuser,
    output logic                                            m_axis_tvalid,
    output logic                                            m_axis_tlast,
    input  logic                                            m_axis_tready
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   w_grant_nxt;
    logic [GW-1:0]   r_last_grant;
    logic [GW-1:0]   w_last_grant_nxt;

    logic            r_m_tvalid;
    logic            r_m_tlast;
    logic [DW-1:0]   r_m_tdata;
    logic [KW-1:0]   r_m_tkeep;
    logic [UW-1:0]   r_m_tuser;

    logic            w_load_ok;
    logic            w_xfer;
    logic            w_req_found;
    logic [GW-1:0]   w_req_idx;
    logic [GW-1:0]   w_cand;

    logic            w_sel_valid;
    logic            w_sel_last;
    logic [DW-1:0]   w_sel_data;
    logic [KW-1:0]   w_sel_keep;
    logic [UW-1:0]   w_sel_user;

    assign w_load_ok = !r_m_tvalid || m_axis_tready;
    assign w_xfer    = (r_state == S_BUSY) && w_sel_valid && w_load_ok;

    // Beat fields of the currently granted port.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_keep  = '0;
        w_sel_user  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_grant == GW'(i)) begin
                w_sel_valid = s_axis_tvalid[i];
                w_sel_last  = s_axis_tlast[i];
                w_sel_data  = s_axis_tdata[i*DW +: DW];
                w_sel_keep  = s_axis_tkeep[i*KW +: KW];
                w_sel_user  = s_axis_tuser[i*UW +: UW];
            end
        end
`ifdef ARB_SRC_TAG_EN
        w_sel_user[SRC_TAG_POS +: 8] = 8'(r_grant);
`endif
    end

    // First requester after last_grant, wrapping around.
    always_comb begin
        w_req_found = 1'b0;
        w_req_idx   = '0;
        w_cand      = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_cand = GW'((int'(r_last_grant) + k) % NUM_PORTS);
            if (!w_req_found && s_axis_tvalid[w_cand]) begin
                w_req_found = 1'b1;
                w_req_idx   = w_cand;
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            s_axis_tready[i] = (r_state == S_BUSY) && (r_grant == GW'(i)) && w_load_ok;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            S_IDLE: begin
                if (w_req_found) begin
                    w_grant_nxt      = w_req_idx;
                    w_last_grant_nxt = w_req_idx;
                    w_state_nxt      = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_xfer && w_sel_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_PORTS - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tuser  <= '0;
        end else if (w_xfer) begin
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= w_sel_last;
            r_m_tdata  <= w_sel_data;
            r_m_tkeep  <= w_sel_keep;
            r_m_tuser  <= w_sel_user;
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tuser  = r_m_tuser;

endmodule

// File: tb/tb_axis_rr_port_arbiter.sv
// Directed bench for axis_rr_port_arbiter: per-port packet sources, per-cycle output log, inline checks.
// Build with ARB_SRC_TAG_EN defined to expect the source-port tag in tuser.

module tb_axis_rr_port_arbiter;

    localparam int DW = 256;
    localparam int KW = DW / 8;
    localparam int UW = 128;
    localparam int NP = 4;

    logic              clk = 1'b0;
    logic              aresetn = 1'b1;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*KW-1:0]  s_tkeep;
    logic [NP*UW-1:0]  s_tuser;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tlast;
    logic [NP-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [UW-1:0]     m_tuser;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int           src_pend [NP];
    int           src_beat [NP];
    int           src_plen [NP];
    int           src_hold [NP];
    logic [7:0]   src_base [NP];
    logic [UW-1:0] src_user [NP];

    logic         log_v [64];
    logic [7:0]   log_d [64];
    logic         log_l [64];

    always #5 clk = ~clk;

    axis_rr_port_arbiter #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .NUM_PORTS            (NP),
        .SRC_TAG_POS          (24)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready)
    );

    task automatic drive_src();
        for (int p = 0; p < NP; p++) begin
            s_tvalid[p] = (src_pend[p] > 0) && (src_hold[p] == 0);
            s_tlast[p]  = (src_beat[p] % src_plen[p]) == (src_plen[p] - 1);
            s_tdata[p*DW +: DW] = DW'(src_base[p] + 8'(src_beat[p]));
            s_tkeep[p*KW +: KW] = KW'((p + 1) * 32'h0101_0101);
            s_tuser[p*UW +: UW] = src_user[p];
        end
    endtask

    task automatic clear_src();
        for (int p = 0; p < NP; p++) begin
            src_pend[p] = 0;
            src_beat[p] = 0;
            src_plen[p] = 1;
            src_hold[p] = 0;
            src_base[p] = 8'h00;
            src_user[p] = '0;
        end
        drive_src();
    endtask

    task automatic load(input int p, input int beats, input int plen, input logic [7:0] base);
        src_pend[p] = beats;
        src_beat[p] = 0;
        src_plen[p] = plen;
        src_hold[p] = 0;
        src_base[p] = base;
        drive_src();
    endtask

    // One clock: handshakes sampled before the edge, sources advanced and outputs logged after it.
    task automatic step();
        logic [NP-1:0] hs;
        @(negedge clk);
        hs = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) begin
                src_pend[p]--;
                src_beat[p]++;
            end
            if (src_hold[p] > 0) src_hold[p]--;
        end
        drive_src();
        if (cyc < 64) begin
            log_v[cyc] = m_tvalid;
            log_d[cyc] = m_tdata[7:0];
            log_l[cyc] = m_tlast;
        end
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        m_tready = 1'b1;
        clear_src();
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        clear_src();
        load(0, 2, 2, 8'h00);
        #2;
        aresetn = 1'b0;
        #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_tvalid); end
        checks++; if (m_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", m_tdata[31:0]); end
        checks++; if (m_tkeep !== '0) begin errors++; $display("FAIL reset_tkeep: got %h expected 0", m_tkeep); end
        checks++; if (m_tuser !== '0) begin errors++; $display("FAIL reset_tuser: got %h expected 0", m_tuser); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", m_tlast); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL reset_tready: got %b expected 0000", s_tready); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_hold_tvalid: got %b expected 0", m_tvalid); end
    endtask

    task automatic test_single_port();
        do_reset();
        load(2, 3, 3, 8'hA0);
        checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL p2_idle_tready: got %b expected 0000", s_tready); end
        step();
        checks++; if (s_tready !== 4'b0100) begin errors++; $display("FAIL p2_grant_tready: got %b expected 0100", s_tready); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL p2_c1_tvalid: got %b expected 0", m_tvalid); end
        step();
        checks++; if (m_tvalid !== 1'b1 || m_tdata[7:0] !== 8'hA0 || m_tlast !== 1'b0) begin errors++; $display("FAIL p2_beat0: got v=%b d=%h l=%b expected v=1 d=a0 l=0", m_tvalid, m_tdata[7:0], m_tlast); end
        checks++; if (m_tkeep !== 32'h0303_0303) begin errors++; $display("FAIL p2_tkeep: got %h expected 03030303", m_tkeep); end
        step();
        checks++; if (m_tvalid !== 1'b1 || m_tdata[7:0] !== 8'hA1 || m_tlast !== 1'b0) begin errors++; $display("FAIL p2_beat1: got v=%b d=%h l=%b expected v=1 d=a1 l=0", m_tvalid, m_tdata[7:0], m_tlast); end
        step();
        checks++; if (m_tvalid !== 1'b1 || m_tdata[7:0] !== 8'hA2 || m_tlast !== 1'b1) begin errors++; $display("FAIL p2_beat2: got v=%b d=%h l=%b expected v=1 d=a2 l=1", m_tvalid, m_tdata[7:0], m_tlast); end
        checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL p2_back_idle: got %b expected 0000", s_tready); end
        step();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL p2_drain: got %b expected 0", m_tvalid); end
    endtask

    task automatic test_round_robin();
        int         ports [5] = '{0, 1, 2, 3, 0};
        int         k;
        int         pos;
        logic       exp_v;
        logic       exp_l;
        logic [7:0] exp_d;
        do_reset();
        load(0, 4, 2, 8'h00);
        load(1, 2, 2, 8'h10);
        load(2, 2, 2, 8'h20);
        load(3, 2, 2, 8'h30);
        repeat (16) step();
        for (int c = 1; c <= 16; c++) begin
            if (c == 1) begin
                exp_v = 1'b0; exp_d = 8'h00; exp_l = 1'b0;
            end else begin
                k     = (c - 2) / 3;
                pos   = (c - 2) % 3;
                exp_v = (pos != 2);
                exp_l = (pos == 1);
                exp_d = 8'(ports[k] * 16 + ((k == 4) ? 2 : 0) + pos);
            end
            checks++;
            if (log_v[c] !== exp_v) begin errors++; $display("FAIL rr_valid c%0d: got %b expected %b", c, log_v[c], exp_v); end
            if (exp_v) begin
                checks++;
                if (log_d[c] !== exp_d || log_l[c] !== exp_l) begin errors++; $display("FAIL rr_beat c%0d: got d=%h l=%b expected d=%h l=%b", c, log_d[c], log_l[c], exp_d, exp_l); end
            end
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        load(0, 1, 1, 8'h00);
        load(1, 1, 1, 8'h10);
        step();
        step();
        checks++; if (m_tdata[7:0] !== 8'h00 || m_tlast !== 1'b1 || m_tvalid !== 1'b1) begin errors++; $display("FAIL sb_p0: got v=%b d=%h l=%b expected v=1 d=00 l=1", m_tvalid, m_tdata[7:0], m_tlast); end
        checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL sb_idle_after_one: got %b expected 0000", s_tready); end
        step();
        checks++; if (m_tvalid !== 1'b0 || s_tready !== 4'b0010) begin errors++; $display("FAIL sb_arb: got v=%b rdy=%b expected v=0 rdy=0010", m_tvalid, s_tready); end
        step();
        checks++; if (m_tdata[7:0] !== 8'h10 || m_tlast !== 1'b1 || m_tvalid !== 1'b1) begin errors++; $display("FAIL sb_p1: got v=%b d=%h l=%b expected v=1 d=10 l=1", m_tvalid, m_tdata[7:0], m_tlast); end
    endtask

    task automatic test_stall();
        do_reset();
        load(1, 3, 3, 8'h10);
        step();
        load(0, 2, 2, 8'h00);
        step();
        checks++; if (m_tvalid !== 1'b1 || m_tdata[7:0] !== 8'h10) begin errors++; $display("FAIL st_beat0: got v=%b d=%h expected v=1 d=10", m_tvalid, m_tdata[7:0]); end
        m_tready = 1'b0;
        #1;
        checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL st_block_now: got %b expected 0000", s_tready); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata[7:0] !== 8'h10 || s_tready !== 4'b0000) begin errors++; $display("FAIL st_frozen c%0d: got v=%b d=%h rdy=%b expected v=1 d=10 rdy=0000", cyc, m_tvalid, m_tdata[7:0], s_tready); end
        end
        m_tready = 1'b1;
        step();
        checks++; if (m_tvalid !== 1'b1 || m_tdata[7:0] !== 8'h11) begin errors++; $display("FAIL st_beat1: got v=%b d=%h expected v=1 d=11", m_tvalid, m_tdata[7:0]); end
        step();
        checks++; if (m_tdata[7:0] !== 8'h12 || m_tlast !== 1'b1) begin errors++; $display("FAIL st_beat2: got d=%h l=%b expected d=12 l=1", m_tdata[7:0], m_tlast); end
        step();
        checks++; if (m_tvalid !== 1'b0 || s_tready !== 4'b0001) begin errors++; $display("FAIL st_next_grant: got v=%b rdy=%b expected v=0 rdy=0001", m_tvalid, s_tready); end
        step();
        checks++; if (m_tvalid !== 1'b1 || m_tdata[7:0] !== 8'h00) begin errors++; $display("FAIL st_p0: got v=%b d=%h expected v=1 d=00", m_tvalid, m_tdata[7:0]); end
    endtask

    task automatic test_drop_valid();
        do_reset();
        load(3, 3, 3, 8'h30);
        step();
        load(0, 2, 2, 8'h00);
        step();
        checks++; if (m_tdata[7:0] !== 8'h30 || m_tvalid !== 1'b1) begin errors++; $display("FAIL dv_beat0: got v=%b d=%h expected v=1 d=30", m_tvalid, m_tdata[7:0]); end
        src_hold[3] = 4;
        drive_src();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (m_tvalid !== 1'b0 || s_tready !== 4'b1000) begin errors++; $display("FAIL dv_gap c%0d: got v=%b rdy=%b expected v=0 rdy=1000", cyc, m_tvalid, s_tready); end
        end
        step();
        checks++; if (m_tvalid !== 1'b1 || m_tdata[7:0] !== 8'h31) begin errors++; $display("FAIL dv_beat1: got v=%b d=%h expected v=1 d=31", m_tvalid, m_tdata[7:0]); end
        step();
        checks++; if (m_tdata[7:0] !== 8'h32 || m_tlast !== 1'b1) begin errors++; $display("FAIL dv_beat2: got d=%h l=%b expected d=32 l=1", m_tdata[7:0], m_tlast); end
        step();
        checks++; if (m_tvalid !== 1'b0 || s_tready !== 4'b0001) begin errors++; $display("FAIL dv_next_grant: got v=%b rdy=%b expected v=0 rdy=0001", m_tvalid, s_tready); end
        step();
        checks++; if (m_tvalid !== 1'b1 || m_tdata[7:0] !== 8'h00) begin errors++; $display("FAIL dv_p0: got v=%b d=%h expected v=1 d=00", m_tvalid, m_tdata[7:0]); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        load(1, 3, 3, 8'h10);
        step();
        step();
        checks++; if (m_tvalid !== 1'b1 || m_tdata[7:0] !== 8'h10) begin errors++; $display("FAIL rm_beat0: got v=%b d=%h expected v=1 d=10", m_tvalid, m_tdata[7:0]); end
        #2;
        aresetn = 1'b0;
        #1;
        checks++; if (m_tvalid !== 1'b0 || m_tdata[7:0] !== 8'h00) begin errors++; $display("FAIL rm_async: got v=%b d=%h expected v=0 d=00", m_tvalid, m_tdata[7:0]); end
        checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL rm_tready: got %b expected 0000", s_tready); end
        clear_src();
        load(0, 2, 2, 8'h00);
        load(1, 2, 2, 8'h10);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        cyc = 0;
        step();
        checks++; if (s_tready !== 4'b0001) begin errors++; $display("FAIL rm_first_grant: got %b expected 0001", s_tready); end
        step();
        checks++; if (m_tvalid !== 1'b1 || m_tdata[7:0] !== 8'h00) begin errors++; $display("FAIL rm_p0: got v=%b d=%h expected v=1 d=00", m_tvalid, m_tdata[7:0]); end
        step();
        step();
        step();
        checks++; if (m_tvalid !== 1'b1 || m_tdata[7:0] !== 8'h10) begin errors++; $display("FAIL rm_p1: got v=%b d=%h expected v=1 d=10", m_tvalid, m_tdata[7:0]); end
    endtask

    task automatic test_src_tag();
        logic [UW-1:0] u;
        logic [UW-1:0] exp_u;
        u     = 128'h0123_4567_89AB_CDEF_FEDC_BA98_5A43_2110;
        exp_u = u;
`ifdef ARB_SRC_TAG_EN
        exp_u[31:24] = 8'h02;
`endif
        do_reset();
        src_user[2] = u;
        load(2, 2, 2, 8'h60);
        step();
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (m_tvalid !== 1'b1 || m_tuser !== exp_u) begin errors++; $display("FAIL tag_tuser c%0d: got v=%b u=%h expected v=1 u=%h", cyc, m_tvalid, m_tuser, exp_u); end
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_round_robin();
        test_single_beat();
        test_stall();
        test_drop_valid();
        test_reset_mid_packet();
        test_src_tag();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
